// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default geometry and the dump reader's state encoding.
package regfile_pkg;

   localparam int ADDR_DEF = 5;
   localparam int NUM_DEF  = 32;
   localparam int SIZE_DEF = 32;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_SEND = 3'd2,
      ST_CSUM = 3'd3,
      ST_DONE = 3'd4
   } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Sequential register-file reader: walks addresses 0..NUM-1 over one read port and streams each word.
// Build option REGFILE_DUMP_CHECKSUM_EN appends an XOR checksum beat after the last register.
module regfile_dump
   import regfile_pkg::*;
#(
   parameter int ADDR = ADDR_DEF,
   parameter int NUM  = NUM_DEF,
   parameter int SIZE = SIZE_DEF
) (
   input  logic            Clk,
   input  logic            reset,
   input  logic            start,
   output logic [ADDR-1:0] R_Addr,
   input  logic [SIZE-1:0] R_Data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] out_data,
   output logic [ADDR-1:0] out_addr,
   output logic            out_last,
   output logic            busy,
   output logic            done,
   output dump_state_t     state
);

   // NUM <= 2**ADDR, so NUM-1 always fits and the walk stops before addr can wrap.
   localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(NUM - 1);

   logic [ADDR-1:0] addr;
   logic            at_last;
`ifdef REGFILE_DUMP_CHECKSUM_EN
   logic [SIZE-1:0] csum;
`endif

   assign at_last = (addr == LAST_ADDR);
   assign R_Addr  = (state == ST_IDLE) ? '0 : addr;

   // Handshake: a beat transfers on the rising Clk edge where out_valid and out_ready are
   // both high; once out_valid rises, out_data/out_addr/out_last hold until that transfer.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         addr      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  addr     <= '0;
                  out_last <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_READ;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                  csum     <= '0;
`endif
               end
            end
            ST_READ: begin
               out_data  <= R_Data;
               out_addr  <= addr;
               out_valid <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
               out_last  <= 1'b0;
               csum      <= csum ^ R_Data;
`else
               out_last  <= at_last;
`endif
               state     <= ST_SEND;
            end
            ST_SEND: begin
               if (out_ready) begin
                  if (at_last) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                     // csum already folded in the last word during READ.
                     out_valid <= 1'b1;
                     out_data  <= csum;
                     out_addr  <= '0;
                     out_last  <= 1'b1;
                     state     <= ST_CSUM;
`else
                     out_valid <= 1'b0;
                     done      <= 1'b1;
                     state     <= ST_DONE;
`endif
                  end else begin
                     out_valid <= 1'b0;
                     addr      <= addr + 1'b1;
                     state     <= ST_READ;
                  end
               end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            ST_CSUM: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  state     <= ST_DONE;
               end
            end
`endif
            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               out_valid <= 1'b0;
               done      <= 1'b0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: register-file model, beat scoreboard fed from the spec's dump rules,
// and a second NUM=4/ADDR=2 instance. Honours REGFILE_DUMP_CHECKSUM_EN when defined.
module tb_regfile_dump;
   import regfile_pkg::*;

   localparam int ADDR   = ADDR_DEF;
   localparam int NUM    = NUM_DEF;
   localparam int SIZE   = SIZE_DEF;
   localparam int BW     = 1 + ADDR + SIZE;
   localparam int S_NUM  = 4;
   localparam int S_ADDR = 2;
   localparam int S_BW   = 1 + S_ADDR + SIZE;
`ifdef REGFILE_DUMP_CHECKSUM_EN
   localparam int CSUM_BEATS = 1;
`else
   localparam int CSUM_BEATS = 0;
`endif
   localparam int EXP_BEATS = NUM + CSUM_BEATS;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            out_ready = 1'b0;
   logic [ADDR-1:0] r_addr;
   logic [SIZE-1:0] r_data;
   logic            out_valid;
   logic [SIZE-1:0] out_data;
   logic [ADDR-1:0] out_addr;
   logic            out_last;
   logic            busy;
   logic            done;
   dump_state_t     a_state;

   logic              b_start = 1'b0;
   logic              b_ready = 1'b0;
   logic [S_ADDR-1:0] b_r_addr;
   logic [SIZE-1:0]   b_r_data;
   logic              b_valid;
   logic [SIZE-1:0]   b_data;
   logic [S_ADDR-1:0] b_addr;
   logic              b_last;
   logic              b_busy;
   logic              b_done;
   dump_state_t       b_state;

   // register file model: R[0] reads as zero
   logic [SIZE-1:0] rf [NUM];
   assign r_data   = (r_addr == '0) ? '0 : rf[r_addr];
   assign b_r_data = (b_r_addr == '0) ? '0 : rf[{3'b000, b_r_addr}];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int ready_pct = 100;
   int s_cyc = 0;
   int beats = 0;
   int dones = 0;
   int done_cyc = -1;
   int first_valid_cyc = -1;
   bit sb_en = 1'b0;
   bit stalled = 1'b0;
   logic [BW-1:0] held;
   logic [BW-1:0] sb_beat;
   logic [BW-1:0] sb_exp;
   logic [BW-1:0] last_beat;
   logic [BW-1:0] exp_q[$];

   regfile_dump u_dut (
      .Clk(clk), .reset(rst_n), .start(start),
      .R_Addr(r_addr), .R_Data(r_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_addr(out_addr), .out_last(out_last),
      .busy(busy), .done(done), .state(a_state)
   );

   regfile_dump #(.ADDR(S_ADDR), .NUM(S_NUM), .SIZE(SIZE)) u_small (
      .Clk(clk), .reset(rst_n), .start(b_start),
      .R_Addr(b_r_addr), .R_Data(b_r_data),
      .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
      .out_addr(b_addr), .out_last(b_last),
      .busy(b_busy), .done(b_done), .state(b_state)
   );

   // clock / cycle counter / ready driver
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 99) < ready_pct);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard: accepted beats must match exp_q in order; stalled beats must hold
   initial forever begin
      @(negedge clk);
      sb_beat = {out_last, out_addr, out_data};
      if (rst_n && sb_en) begin
         if (stalled) begin
            checks++;
            if (!out_valid || sb_beat !== held) begin
               failures++;
               $display("FAIL hold_stable cyc=%0d got valid=%0b beat=%h required valid=1 beat=%h",
                        cyc, out_valid, sb_beat, held);
            end
         end
         if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL extra_beat got=%h required=none", sb_beat);
            end else begin
               sb_exp = exp_q.pop_front();
               if (sb_beat !== sb_exp) begin
                  failures++;
                  $display("FAIL beat_value idx=%0d got=%h required=%h", beats, sb_beat, sb_exp);
               end
            end
            beats++;
            last_beat = sb_beat;
         end
         stalled = out_valid && !out_ready;
         held = sb_beat;
         if (done) begin
            dones++;
            done_cyc = cyc;
         end
      end else begin
         stalled = 1'b0;
      end
   end

   // expected dump derived from the register contents
   function automatic void build_expected();
      logic [SIZE-1:0] x;
      logic [SIZE-1:0] d;
      x = '0;
      exp_q.delete();
      for (int k = 0; k < NUM; k++) begin
         d = (k == 0) ? '0 : rf[k];
         x = x ^ d;
         exp_q.push_back({1'(CSUM_BEATS == 0 && k == NUM - 1), ADDR'(k), d});
      end
      if (CSUM_BEATS != 0) exp_q.push_back({1'b1, ADDR'(0), x});
   endfunction

   task automatic prep_dump();
      beats = 0;
      dones = 0;
      done_cyc = -1;
      first_valid_cyc = -1;
      build_expected();
      sb_en = 1'b1;
   endtask

   task automatic start_pulse();
      @(negedge clk);
      start = 1'b1;
      s_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (dones > 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({r_addr, out_valid, out_data, out_addr, out_last, busy, done} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h required=0",
                  {r_addr, out_valid, out_data, out_addr, out_last, busy, done});
      end
      checks++;
      if (a_state !== ST_IDLE) begin
         failures++;
         $display("FAIL reset_state got=%0d required=%0d", a_state, ST_IDLE);
      end
      checks++;
      if ({b_r_addr, b_valid, b_data, b_addr, b_last, b_busy, b_done} !== '0) begin
         failures++;
         $display("FAIL reset_outputs_small got=%h required=0",
                  {b_r_addr, b_valid, b_data, b_addr, b_last, b_busy, b_done});
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset got valid=%0b busy=%0b required 0 0", out_valid, busy);
      end
   endtask

   task automatic test_full_dump();
      bit ok;
      for (int k = 0; k < NUM; k++) rf[k] = (k == 0) ? '0 : SIZE'(k * 3 + 1);
      ready_pct = 100;
      prep_dump();
      start_pulse();
      wait_done(400, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL full_done_timeout got=no_done required=done");
      end
      checks++;
      if (beats != EXP_BEATS || exp_q.size() != 0) begin
         failures++;
         $display("FAIL full_beat_count got=%0d left=%0d required=%0d left=0", beats, exp_q.size(), EXP_BEATS);
      end
      checks++;
      if (first_valid_cyc - s_cyc != 2) begin
         failures++;
         $display("FAIL full_first_valid_latency got=%0d required=2", first_valid_cyc - s_cyc);
      end
      checks++;
      if (done_cyc - s_cyc + 1 != 2 * NUM + 2 + CSUM_BEATS) begin
         failures++;
         $display("FAIL full_start_to_done got=%0d required=%0d", done_cyc - s_cyc + 1, 2 * NUM + 2 + CSUM_BEATS);
      end
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || a_state !== ST_IDLE || dones != 1) begin
         failures++;
         $display("FAIL full_return_idle got busy=%0b done=%0b dones=%0d required 0 0 1", busy, done, dones);
      end
   endtask

   task automatic test_random_ready();
      bit ok;
      for (int k = 0; k < NUM; k++) rf[k] = $urandom;
      ready_pct = 30;
      prep_dump();
      start_pulse();
      wait_done(3000, ok);
      repeat (4) @(negedge clk);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL random_done_timeout got=no_done required=done");
      end
      checks++;
      if (beats != EXP_BEATS || exp_q.size() != 0 || dones != 1) begin
         failures++;
         $display("FAIL random_beat_count got beats=%0d dones=%0d required beats=%0d dones=1", beats, dones, EXP_BEATS);
      end
   endtask

   task automatic test_start_ignored();
      bit p_mid;
      bit p_done;
      for (int k = 0; k < NUM; k++) rf[k] = $urandom;
      ready_pct = 70;
      prep_dump();
      start_pulse();
      p_mid = 1'b0;
      p_done = 1'b0;
      for (int i = 0; i < 2000 && !p_done; i++) begin
         @(negedge clk);
         #1;
         if (!p_mid && beats >= 10) begin
            start = 1'b1;
            p_mid = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end else if (done) begin
            start = 1'b1;
            p_done = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      end
      repeat (6) @(negedge clk);
      #1;
      checks++;
      if (!p_done) begin
         failures++;
         $display("FAIL ignore_done_timeout got=no_done required=done");
      end
      checks++;
      if (beats != EXP_BEATS || exp_q.size() != 0 || dones != 1) begin
         failures++;
         $display("FAIL ignore_start got beats=%0d dones=%0d required beats=%0d dones=1", beats, dones, EXP_BEATS);
      end
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL ignore_start_idle got busy=%0b valid=%0b required 0 0", busy, out_valid);
      end
   endtask

   task automatic test_reset_mid_dump();
      bit found;
      bit ok;
      for (int k = 0; k < NUM; k++) rf[k] = $urandom;
      ready_pct = 100;
      prep_dump();
      start_pulse();
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         #1;
         if (out_valid && out_addr == ADDR'(17)) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL midreset_reach_beat17 got=not_reached required=reached");
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({r_addr, out_valid, out_data, out_addr, out_last, busy, done} !== '0 || a_state !== ST_IDLE) begin
         failures++;
         $display("FAIL midreset_outputs got=%h state=%0d required=0 state=0",
                  {r_addr, out_valid, out_data, out_addr, out_last, busy, done}, a_state);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      prep_dump();
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (beats != 0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midreset_abandoned got beats=%0d busy=%0b required beats=0 busy=0", beats, busy);
      end
      start_pulse();
      wait_done(400, ok);
      checks++;
      if (!ok || beats != EXP_BEATS || exp_q.size() != 0) begin
         failures++;
         $display("FAIL midreset_fresh_dump got beats=%0d done=%0b required beats=%0d done=1", beats, ok, EXP_BEATS);
      end
   endtask

   task automatic test_onehot_last();
      bit ok;
      logic [BW-1:0] want;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      want = {1'b1, ADDR'(0), 32'hFFFF_FFFE};
`else
      want = {1'b1, ADDR'(NUM - 1), 32'h8000_0000};
`endif
      for (int k = 0; k < NUM; k++) rf[k] = SIZE'(1) << k;
      ready_pct = 50;
      prep_dump();
      start_pulse();
      wait_done(2000, ok);
      checks++;
      if (!ok || beats != EXP_BEATS || exp_q.size() != 0) begin
         failures++;
         $display("FAIL onehot_beat_count got beats=%0d done=%0b required beats=%0d done=1", beats, ok, EXP_BEATS);
      end
      checks++;
      if (last_beat !== want) begin
         failures++;
         $display("FAIL onehot_last_beat got=%h required=%h", last_beat, want);
      end
   endtask

   task automatic test_small_num();
      logic [S_BW-1:0] bq[$];
      logic [S_BW-1:0] got;
      logic [S_BW-1:0] e;
      logic [SIZE-1:0] x;
      logic [SIZE-1:0] d;
      int n;
      int nd;
      x = '0;
      for (int k = 0; k < S_NUM; k++) begin
         d = (k == 0) ? '0 : rf[k];
         x = x ^ d;
         bq.push_back({1'(CSUM_BEATS == 0 && k == S_NUM - 1), S_ADDR'(k), d});
      end
      if (CSUM_BEATS != 0) bq.push_back({1'b1, S_ADDR'(0), x});
      b_ready = 1'b1;
      @(negedge clk);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      n = 0;
      nd = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         #1;
         if (b_valid && b_ready) begin
            got = {b_last, b_addr, b_data};
            checks++;
            if (bq.size() == 0) begin
               failures++;
               $display("FAIL small_extra_beat got=%h required=none", got);
            end else begin
               e = bq.pop_front();
               if (got !== e) begin
                  failures++;
                  $display("FAIL small_beat idx=%0d got=%h required=%h", n, got, e);
               end
            end
            n++;
         end
         if (b_done) nd++;
      end
      checks++;
      if (n != S_NUM + CSUM_BEATS || nd != 1 || b_busy !== 1'b0) begin
         failures++;
         $display("FAIL small_summary got beats=%0d dones=%0d busy=%0b required beats=%0d dones=1 busy=0",
                  n, nd, b_busy, S_NUM + CSUM_BEATS);
      end
   endtask

   initial begin
      for (int k = 0; k < NUM; k++) rf[k] = '0;
      test_reset();
      test_full_dump();
      test_random_ready();
      test_start_ignored();
      test_reset_mid_dump();
      test_onehot_last();
      test_small_num();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
